param_serial_adder: RTL and testbench
=====================================

PARAM_SERIAL_ADDER -- requirements
Module: param_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand and sum width in bits; legal range 1..32.
REQ-002 SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have start  input  1  request to add a and b; sampled only in IDLE.
REQ-005 SHALL have a  input  WIDTH  operand A, captured on the accepted start edge.
REQ-006 SHALL have b  input  WIDTH  operand B, captured on the accepted start edge.
REQ-007 SHALL have busy  output  1  high while an addition is in progress (RUN state).
REQ-008 SHALL have done  output  1  one-cycle pulse marking s/cout valid for a new result.
REQ-009 SHALL have s  output  WIDTH  registered sum, a+b modulo 2^WIDTH.
REQ-010 SHALL have cout  output  1  registered carry out of bit WIDTH-1.

Function
REQ-011 SHALL implement states IDLE, RUN, DONE, one-hot or binary; no other reachable states.
REQ-012 IDLE: start=1 at an edge SHALL load operand shift registers from a/b, clear internal carry to 0, clear bit counter to 0, go RUN.
REQ-013 IDLE with start=0 SHALL stay IDLE; s, cout hold their last values.
REQ-014 RUN: each cycle SHALL form bit = A[0] ^ B[0] ^ c and next c = majority(A[0], B[0], c); this full-add is the half-adder pair plus carry register.
REQ-015 RUN: each cycle SHALL shift A and B right by one, shift bit into internal sum register from the MSB end, and increment the counter.
REQ-016 RUN SHALL last exactly WIDTH cycles; at the edge where counter = WIDTH-1 the final bit is processed and the state goes to DONE.
REQ-017 On the RUN->DONE edge, s SHALL load the completed internal sum and cout the final carry; s/cout SHALL NOT change at any other time except reset.
REQ-018 DONE SHALL last one cycle, then go IDLE unconditionally.
REQ-019 busy SHALL equal (state==RUN); done SHALL equal (state==DONE); both registered/state-decoded, glitch-free.
REQ-020 Latency: start sampled at edge 0 -> busy high from edge 0 to edge WIDTH, done high from edge WIDTH to edge WIDTH+1; new start accepted no earlier than edge WIDTH+1.
REQ-021 start while in RUN or DONE SHALL be ignored (no restart, no queuing); a/b changes after capture SHALL not affect the result.
REQ-022 Overflow: sum wraps modulo 2^WIDTH with carry reported on cout; no saturation.
REQ-023 WIDTH=1 SHALL work: RUN one cycle, s = a^b, cout = a&b.
REQ-024 Counter SHALL be clog2(WIDTH)+1 bits wide minimum; no wrap-around within a RUN.

Reset
REQ-025 rst=1 at an edge SHALL force state IDLE, busy=0, done=0, s=0, cout=0, internal carry, counter and shift registers to 0.
REQ-026 rst SHALL take priority over start and over any in-progress RUN; an aborted addition produces no done pulse and no change to s beyond the reset value.
REQ-027 First start SHALL be accepted on the first edge after rst deasserts.

Verification
REQ-028 WIDTH=4: a=3, b=5, start one cycle -> busy 4 cycles, then done pulse with s=8, cout=0.
REQ-029 WIDTH=4: a=15, b=1 -> s=0, cout=1; then a=15, b=15 -> s=14, cout=1; s holds between runs.
REQ-030 WIDTH=1: all four a/b pairs (00,10,01,11) -> (s,cout) = (0,0),(1,0),(1,0),(0,1), each after 1 busy cycle.
REQ-031 WIDTH=4: start a=2,b=2, then at RUN cycle 2 pulse start with a=7,b=7 and change a/b -> ignored; result s=4, cout=0.
REQ-032 WIDTH=4: rst asserted at RUN cycle 2 -> next cycle busy=0, done=0, s=0, cout=0; no done pulse follows; a fresh start then completes correctly.
REQ-033 WIDTH=8: randomized a/b for 200 back-to-back starts (start held high) -> each done matches reference a+b, one start accepted per WIDTH+2 cycles.

Source files
------------

// File: rtl/param_serial_adder.sv
// rtl/param_serial_adder.sv - bit-serial adder, one full-add per cycle, LSB first
// Operands shift out LSB first; sum bits enter from the MSB end of the sum register.

module param_serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_bit;
    logic             fa_carry;

    always_comb begin
        fa_bit   = a_q[0] ^ b_q[0] ^ c_q;
        fa_carry = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        s_d     = s_q;
        c_d     = c_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sum_d   = '0;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                sum_d = (sum_q >> 1) | (WIDTH'(fa_bit) << (WIDTH - 1));
                c_d   = fa_carry;
                cnt_d = cnt_q + CW'(1);
                // The last bit is folded into sum_d in this same cycle, so publish sum_d.
                if (cnt_q == LAST) begin
                    s_d     = sum_d;
                    cout_d  = fa_carry;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            s_q     <= s_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign s    = s_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_param_serial_adder.sv
// tb/tb_param_serial_adder.sv - scoreboard bench for param_serial_adder at WIDTH 1, 4 and 8
// Expected {cout,s} is plain a+b pushed at issue time; per-instance monitors pop on done.

module tb_param_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    logic       rst1 = 1'b1, start1 = 1'b0, busy1, done1, cout1;
    logic [0:0] a1 = '0, b1 = '0, s1;
    logic       rst4 = 1'b1, start4 = 1'b0, busy4, done4, cout4;
    logic [3:0] a4 = '0, b4 = '0, s4;
    logic       rst8 = 1'b1, start8 = 1'b0, busy8, done8, cout8;
    logic [7:0] a8 = '0, b8 = '0, s8;

    param_serial_adder #(.WIDTH(1)) u_w1 (.clk(clk), .rst(rst1), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .s(s1), .cout(cout1));
    param_serial_adder #(.WIDTH(4)) u_w4 (.clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .s(s4), .cout(cout4));
    param_serial_adder #(.WIDTH(8)) u_w8 (.clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .s(s8), .cout(cout8));

    int q1[$];
    int q4[$];
    int q8[$];

    logic r1_e = 1'b1, r4_e = 1'b1, r8_e = 1'b1;
    always @(posedge clk) begin
        r1_e <= rst1;
        r4_e <= rst4;
        r8_e <= rst8;
    end

    int blen1 = 0, blen4 = 0, blen8 = 0;
    int last1 = 0, last4 = 0, last8 = 0;
    int gap8 = 0;
    bit b2b8 = 1'b0, seen8 = 1'b0;

    always @(negedge clk) begin
        if (r1_e) begin
            blen1 = 0;
            last1 = 0;
            chk("w1_reset_state", {busy1, done1, cout1, s1}, 0);
        end else begin
            chk("w1_busy_done_excl", busy1 & done1, 0);
            if (busy1) blen1++;
            if (done1) begin
                chk("w1_done_expected", q1.size() > 0, 1);
                if (q1.size() > 0) chk("w1_sum", {cout1, s1}, q1.pop_front());
                chk("w1_busy_len", blen1, 1);
                blen1 = 0;
                last1 = {cout1, s1};
            end else begin
                chk("w1_s_hold", {cout1, s1}, last1);
            end
        end
    end

    always @(negedge clk) begin
        if (r4_e) begin
            blen4 = 0;
            last4 = 0;
            chk("w4_reset_state", {busy4, done4, cout4, s4}, 0);
        end else begin
            chk("w4_busy_done_excl", busy4 & done4, 0);
            if (busy4) blen4++;
            if (done4) begin
                chk("w4_done_expected", q4.size() > 0, 1);
                if (q4.size() > 0) chk("w4_sum", {cout4, s4}, q4.pop_front());
                chk("w4_busy_len", blen4, 4);
                blen4 = 0;
                last4 = {cout4, s4};
            end else begin
                chk("w4_s_hold", {cout4, s4}, last4);
            end
        end
    end

    always @(negedge clk) begin
        gap8++;
        if (r8_e) begin
            blen8 = 0;
            last8 = 0;
            chk("w8_reset_state", {busy8, done8, cout8, s8}, 0);
        end else begin
            chk("w8_busy_done_excl", busy8 & done8, 0);
            if (busy8) blen8++;
            if (done8) begin
                chk("w8_done_expected", q8.size() > 0, 1);
                if (q8.size() > 0) chk("w8_sum", {cout8, s8}, q8.pop_front());
                chk("w8_busy_len", blen8, 8);
                if (b2b8 && seen8) chk("w8_start_period", gap8, 10);
                seen8 = b2b8;
                gap8  = 0;
                blen8 = 0;
                last8 = {cout8, s8};
            end else begin
                chk("w8_s_hold", {cout8, s8}, last8);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b);
        a4 = a;
        b4 = b;
        start4 = 1'b1;
        q4.push_back(int'(a) + int'(b));
        tick();
        start4 = 1'b0;
        repeat (5) tick();
    endtask

    task automatic op1(input logic a, input logic b);
        a1 = a;
        b1 = b;
        start1 = 1'b1;
        q1.push_back(int'(a) + int'(b));
        tick();
        start1 = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int drain;
        logic [7:0] ra, rb;
        tick();
        tick();
        rst1 = 1'b0;
        rst4 = 1'b0;
        rst8 = 1'b0;
        // first edge after reset release must accept start
        op4(4'd3, 4'd5);
        op4(4'd15, 4'd1);
        op4(4'd15, 4'd15);
        repeat (3) tick();

        // restart attempt mid-run plus operand changes must be ignored
        a4 = 4'd2; b4 = 4'd2; start4 = 1'b1;
        q4.push_back(4);
        tick();
        start4 = 1'b0;
        tick();
        a4 = 4'd7; b4 = 4'd7; start4 = 1'b1;
        tick();
        start4 = 1'b0; a4 = 4'd9; b4 = 4'd12;
        repeat (5) tick();

        // reset in the middle of a run: no done, outputs cleared
        a4 = 4'd5; b4 = 4'd6; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0;
        repeat (8) tick();
        op4(4'd9, 4'd4);

        for (int i = 0; i < 20; i++) op4(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

        op1(1'b0, 1'b0);
        op1(1'b1, 1'b0);
        op1(1'b0, 1'b1);
        op1(1'b1, 1'b1);

        b2b8 = 1'b1;
        start8 = 1'b1;
        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (i == 0) begin ra = 8'hFF; rb = 8'h01; end
            if (i == 1) begin ra = 8'hFF; rb = 8'hFF; end
            a8 = ra;
            b8 = rb;
            q8.push_back(int'(ra) + int'(rb));
            repeat (10) tick();
        end
        start8 = 1'b0;

        drain = 0;
        while ((q1.size() + q4.size() + q8.size()) > 0 && drain < 100) begin
            tick();
            drain++;
        end
        repeat (3) tick();
        chk("scoreboard_drained", q1.size() + q4.size() + q8.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
